// File: rtl/pipe_skid_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake, flush and an optional
// 2-entry skid buffer that makes in_ready a registered output.
module pipe_skid_reg #(
    parameter int unsigned       DATA_W      = 160,
    parameter logic [DATA_W-1:0] RST_VAL     = {DATA_W{1'b0}},
    parameter bit                SKID        = 1'b1,
    parameter bit                ZERO_BUBBLE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic              m_v_q, m_v_d;
    logic              s_v_q, s_v_d;
    logic [DATA_W-1:0] m_d_q;
    logic [DATA_W-1:0] s_d_q;
    logic [1:0]        occ_q, occ_d;
    logic              accept;
    logic              emit;
    logic              m_load;
    logic              m_from_skid;
    logic              s_load;

    // With the skid buffer, in_ready depends only on a flop, never on out_ready.
    assign in_ready  = SKID ? !s_v_q : (!m_v_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign emit      = m_v_q && out_ready;
    assign out_valid = m_v_q;
    assign out_data  = (ZERO_BUBBLE && !m_v_q) ? RST_VAL : m_d_q;
    assign occupancy = occ_q;

    always_comb begin
        m_v_d       = m_v_q;
        s_v_d       = s_v_q;
        m_load      = 1'b0;
        m_from_skid = 1'b0;
        s_load      = 1'b0;
        if (flush) begin
            m_v_d = 1'b0;
            s_v_d = 1'b0;
        end else if (!m_v_q) begin
            if (accept) begin
                m_v_d  = 1'b1;
                m_load = 1'b1;
            end
        end else if (!s_v_q) begin
            if (accept && emit) begin
                m_load = 1'b1;
            end else if (accept && SKID) begin
                s_v_d  = 1'b1;
                s_load = 1'b1;
            end else if (emit) begin
                m_v_d = 1'b0;
            end
        end else if (emit) begin
            m_from_skid = 1'b1;
            s_v_d       = 1'b0;
        end
        occ_d = {1'b0, m_v_d} + {1'b0, s_v_d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_v_q <= 1'b0;
            s_v_q <= 1'b0;
            occ_q <= 2'd0;
        end else begin
            m_v_q <= m_v_d;
            s_v_q <= s_v_d;
            occ_q <= occ_d;
        end
    end

    // Data registers load only on real transfers so they can be clock-gated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_d_q <= RST_VAL;
            s_d_q <= RST_VAL;
        end else begin
            if (m_load) begin
                m_d_q <= in_data;
            end else if (m_from_skid) begin
                m_d_q <= s_d_q;
            end
            if (s_load) begin
                s_d_q <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: skid mode, combinational-ready mode and
// non-zeroing bubble mode, each with its own instance.
module tb_pipe_skid_reg;

    localparam int unsigned DW = 8;
    localparam logic [DW-1:0] RV = 8'hA5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic          a_flush = 0, a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0;
    logic [DW-1:0] a_in_data = '0, a_out_data;
    logic [1:0]    a_occ;
    logic          b_flush = 0, b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 0;
    logic [DW-1:0] b_in_data = '0, b_out_data;
    logic [1:0]    b_occ;
    logic          c_flush = 0, c_in_valid = 0, c_in_ready, c_out_valid, c_out_ready = 0;
    logic [DW-1:0] c_in_data = '0, c_out_data;
    logic [1:0]    c_occ;

    always #5 clk = ~clk;

    pipe_skid_reg #(.DATA_W(DW), .RST_VAL(RV), .SKID(1'b1), .ZERO_BUBBLE(1'b1)) dut_a (
        .clk(clk), .rst(rst), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .occupancy(a_occ)
    );

    pipe_skid_reg #(.DATA_W(DW), .RST_VAL(RV), .SKID(1'b0), .ZERO_BUBBLE(1'b1)) dut_b (
        .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .occupancy(b_occ)
    );

    pipe_skid_reg #(.DATA_W(DW), .RST_VAL(RV), .SKID(1'b1), .ZERO_BUBBLE(1'b0)) dut_c (
        .clk(clk), .rst(rst), .flush(c_flush), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_data(c_out_data), .occupancy(c_occ)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        chk("rst_a_valid", 16'(a_out_valid), 16'h0);
        chk("rst_a_data", 16'(a_out_data), 16'(RV));
        chk("rst_a_occ", 16'(a_occ), 16'h0);
        chk("rst_c_data", 16'(c_out_data), 16'(RV));
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 16'(a_in_ready), 16'h1);

        // Streaming with 1-cycle latency.
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            a_in_data = DW'(i);
            #1;
            chk("stream_ready", 16'(a_in_ready), 16'h1);
            tick();
            chk("stream_valid", 16'(a_out_valid), 16'h1);
            chk("stream_data", 16'(a_out_data), 16'(i));
        end
        a_in_valid = 1'b0;
        tick();
        chk("stream_end_valid", 16'(a_out_valid), 16'h0);
        chk("stream_end_bubble", 16'(a_out_data), 16'(RV));

        // Backpressure fill and drain.
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 8'h11;
        tick();
        a_in_data = 8'h22;
        tick();
        a_in_valid = 1'b0;
        #1;
        chk("bp_occ_full", 16'(a_occ), 16'h2);
        chk("bp_ready_low", 16'(a_in_ready), 16'h0);
        chk("bp_data_head", 16'(a_out_data), 16'h11);
        tick();
        chk("bp_hold_data", 16'(a_out_data), 16'h11);
        chk("bp_hold_valid", 16'(a_out_valid), 16'h1);
        a_out_ready = 1'b1;
        tick();
        chk("bp_drain2_data", 16'(a_out_data), 16'h22);
        chk("bp_drain_ready", 16'(a_in_ready), 16'h1);
        chk("bp_drain_occ", 16'(a_occ), 16'h1);
        tick();
        chk("bp_empty_valid", 16'(a_out_valid), 16'h0);
        chk("bp_empty_occ", 16'(a_occ), 16'h0);

        // Flush with a simultaneous accept from state ONE.
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 8'h33;
        tick();
        chk("fl_one_data", 16'(a_out_data), 16'h33);
        a_flush   = 1'b1;
        a_in_data = 8'h44;
        tick();
        a_flush    = 1'b0;
        a_in_valid = 1'b0;
        #1;
        chk("fl_valid", 16'(a_out_valid), 16'h0);
        chk("fl_occ", 16'(a_occ), 16'h0);
        chk("fl_bubble", 16'(a_out_data), 16'(RV));
        chk("fl_ready", 16'(a_in_ready), 16'h1);
        tick();
        chk("fl_no_44", 16'(a_out_valid), 16'h0);

        // Asynchronous reset while FULL.
        a_in_valid = 1'b1;
        a_in_data  = 8'h77;
        tick();
        a_in_data = 8'h88;
        tick();
        a_in_valid = 1'b0;
        #1;
        chk("mr_full_occ", 16'(a_occ), 16'h2);
        rst = 1'b1;
        #1;
        chk("mr_valid", 16'(a_out_valid), 16'h0);
        chk("mr_data", 16'(a_out_data), 16'(RV));
        chk("mr_occ", 16'(a_occ), 16'h0);
        tick();
        rst = 1'b0;
        #1;
        chk("mr_ready", 16'(a_in_ready), 16'h1);
        tick();
        chk("mr_still_empty", 16'(a_out_valid), 16'h0);

        // Combinational ready without the skid buffer.
        b_out_ready = 1'b0;
        b_in_valid  = 1'b1;
        b_in_data   = 8'h50;
        tick();
        chk("ns_occ1", 16'(b_occ), 16'h1);
        chk("ns_ready_low", 16'(b_in_ready), 16'h0);
        b_in_data   = 8'h55;
        b_out_ready = 1'b1;
        #1;
        chk("ns_ready_comb", 16'(b_in_ready), 16'h1);
        tick();
        chk("ns_data", 16'(b_out_data), 16'h55);
        chk("ns_occ_max", 16'(b_occ), 16'h1);
        b_in_valid = 1'b0;
        tick();
        chk("ns_empty", 16'(b_out_valid), 16'h0);

        // Bubble keeps the last payload when zeroing is disabled.
        c_out_ready = 1'b1;
        c_in_valid  = 1'b1;
        c_in_data   = 8'h66;
        tick();
        chk("nz_data", 16'(c_out_data), 16'h66);
        c_in_valid = 1'b0;
        tick();
        chk("nz_valid", 16'(c_out_valid), 16'h0);
        chk("nz_hold", 16'(c_out_data), 16'h66);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
